// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the MIPS datapath stages.
// ex_ctrl_t bundles the decode control bits consumed by Execute and later stages.
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int ALU_CTRL_W = 4;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-Execute bundle: D-side inputs, stage controls and registered E-side outputs.
// master = decode/hazard side driving the stage; slave = the ID/EX register itself.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int REG_ADDR_W = 5
) ();
    logic                  en;
    logic                  flushE;
    logic                  control_mux;
    logic                  reg_writeD, mem_to_regD, mem_readD, mem_writeD, alu_srcD, reg_dstD;
    logic [ALU_CTRL_W-1:0] alu_ctrlD;
    logic [DATA_W-1:0]     rd1D, rd2D, imm_extD, pc_plus4D;
    logic [REG_ADDR_W-1:0] rs_addrD, rt_addrD, rd_addrD;

    logic                  reg_writeE, mem_to_regE, mem_readE, mem_writeE, alu_srcE, reg_dstE;
    logic [ALU_CTRL_W-1:0] alu_ctrlE;
    logic [DATA_W-1:0]     rd1E, rd2E, imm_extE, pc_plus4E;
    logic [REG_ADDR_W-1:0] rs_addrE, rt_addrE, rd_addrE;
    logic                  validE;
    logic [31:0]           bubble_cnt;

    modport master (
        output en, flushE, control_mux,
        output reg_writeD, mem_to_regD, mem_readD, mem_writeD, alu_srcD, reg_dstD, alu_ctrlD,
        output rd1D, rd2D, imm_extD, pc_plus4D, rs_addrD, rt_addrD, rd_addrD,
        input  reg_writeE, mem_to_regE, mem_readE, mem_writeE, alu_srcE, reg_dstE, alu_ctrlE,
        input  rd1E, rd2E, imm_extE, pc_plus4E, rs_addrE, rt_addrE, rd_addrE, validE, bubble_cnt
    );

    modport slave (
        input  en, flushE, control_mux,
        input  reg_writeD, mem_to_regD, mem_readD, mem_writeD, alu_srcD, reg_dstD, alu_ctrlD,
        input  rd1D, rd2D, imm_extD, pc_plus4D, rs_addrD, rt_addrD, rd_addrD,
        output reg_writeE, mem_to_regE, mem_readE, mem_writeE, alu_srcE, reg_dstE, alu_ctrlE,
        output rd1E, rd2E, imm_extE, pc_plus4E, rs_addrE, rt_addrE, rd_addrE, validE, bubble_cnt
    );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset, enable, and clear (load zero).
// Priority: rst > hold (!en) > clear > load.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst)
            q_reg <= '0;
        else if (en)
            q_reg <= clear ? '0 : d;
    end

    assign q = q_reg;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush and load-use bubble injection.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int ALU_CTRL_W = pipe_pkg::ALU_CTRL_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flushE,
    input  logic                  control_mux,
    input  logic                  reg_writeD,
    input  logic                  mem_to_regD,
    input  logic                  mem_readD,
    input  logic                  mem_writeD,
    input  logic                  alu_srcD,
    input  logic                  reg_dstD,
    input  logic [ALU_CTRL_W-1:0] alu_ctrlD,
    input  logic [DATA_W-1:0]     rd1D,
    input  logic [DATA_W-1:0]     rd2D,
    input  logic [DATA_W-1:0]     imm_extD,
    input  logic [DATA_W-1:0]     pc_plus4D,
    input  logic [REG_ADDR_W-1:0] rs_addrD,
    input  logic [REG_ADDR_W-1:0] rt_addrD,
    input  logic [REG_ADDR_W-1:0] rd_addrD,
    output logic                  reg_writeE,
    output logic                  mem_to_regE,
    output logic                  mem_readE,
    output logic                  mem_writeE,
    output logic                  alu_srcE,
    output logic                  reg_dstE,
    output logic [ALU_CTRL_W-1:0] alu_ctrlE,
    output logic [DATA_W-1:0]     rd1E,
    output logic [DATA_W-1:0]     rd2E,
    output logic [DATA_W-1:0]     imm_extE,
    output logic [DATA_W-1:0]     pc_plus4E,
    output logic [REG_ADDR_W-1:0] rs_addrE,
    output logic [REG_ADDR_W-1:0] rt_addrE,
    output logic [REG_ADDR_W-1:0] rd_addrE,
    output logic                  validE,
    output logic [31:0]           bubble_cnt
);
    // Control register carries the valid bit in its LSB so bubbles clear it too.
    localparam int CTRL_W = $bits(ex_ctrl_t) + 1;
    localparam int DAT_W  = 4 * DATA_W + 3 * REG_ADDR_W;

    ex_ctrl_t          ctrl_next;
    ex_ctrl_t          ctrl_reg;
    logic [CTRL_W-1:0] ctrl_bus_next;
    logic [CTRL_W-1:0] ctrl_bus_reg;
    logic [DAT_W-1:0]  data_bus_next;
    logic [DAT_W-1:0]  data_bus_reg;

    logic stage_en;
    logic ctrl_clear;
    logic data_clear;

    // Flush must squash even while the stage is stalled, so it also acts as an enable.
    assign stage_en   = en | flushE;
    assign ctrl_clear = flushE | ~control_mux;
    assign data_clear = flushE;

    always_comb begin
        ctrl_next            = EX_CTRL_NOP;
        ctrl_next.reg_write  = reg_writeD;
        ctrl_next.mem_to_reg = mem_to_regD;
        ctrl_next.mem_read   = mem_readD;
        ctrl_next.mem_write  = mem_writeD;
        ctrl_next.alu_src    = alu_srcD;
        ctrl_next.reg_dst    = reg_dstD;
        ctrl_next.alu_ctrl   = alu_ctrlD;
    end

    assign ctrl_bus_next = {ctrl_next, 1'b1};
    assign data_bus_next = {rd1D, rd2D, imm_extD, pc_plus4D, rs_addrD, rt_addrD, rd_addrD};

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (stage_en),
        .clear (ctrl_clear),
        .d     (ctrl_bus_next),
        .q     (ctrl_bus_reg)
    );

    // A load-use bubble keeps operands and addresses; only a flush zeroes them.
    pipe_reg #(.W(DAT_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (stage_en),
        .clear (data_clear),
        .d     (data_bus_next),
        .q     (data_bus_reg)
    );

    assign ctrl_reg    = ex_ctrl_t'(ctrl_bus_reg[CTRL_W-1:1]);
    assign validE      = ctrl_bus_reg[0];
    assign reg_writeE  = ctrl_reg.reg_write;
    assign mem_to_regE = ctrl_reg.mem_to_reg;
    assign mem_readE   = ctrl_reg.mem_read;
    assign mem_writeE  = ctrl_reg.mem_write;
    assign alu_srcE    = ctrl_reg.alu_src;
    assign reg_dstE    = ctrl_reg.reg_dst;
    assign alu_ctrlE   = ctrl_reg.alu_ctrl;

    assign {rd1E, rd2E, imm_extE, pc_plus4E, rs_addrE, rt_addrE, rd_addrE} = data_bus_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;
    logic        cnt_inc;

    // Every inserted bubble counts, including a flush that lands during a stall.
    assign cnt_inc = flushE | (en & ~control_mux);

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_inc && (cnt_reg != 32'hFFFF_FFFF))
            cnt_next = cnt_reg + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

    assign bubble_cnt = cnt_reg;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for the ID/EX register: reset, load, bubble, stall, flush,
// plus bubble counter saturation when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .flushE      (bus.flushE),
        .control_mux (bus.control_mux),
        .reg_writeD  (bus.reg_writeD),
        .mem_to_regD (bus.mem_to_regD),
        .mem_readD   (bus.mem_readD),
        .mem_writeD  (bus.mem_writeD),
        .alu_srcD    (bus.alu_srcD),
        .reg_dstD    (bus.reg_dstD),
        .alu_ctrlD   (bus.alu_ctrlD),
        .rd1D        (bus.rd1D),
        .rd2D        (bus.rd2D),
        .imm_extD    (bus.imm_extD),
        .pc_plus4D   (bus.pc_plus4D),
        .rs_addrD    (bus.rs_addrD),
        .rt_addrD    (bus.rt_addrD),
        .rd_addrD    (bus.rd_addrD),
        .reg_writeE  (bus.reg_writeE),
        .mem_to_regE (bus.mem_to_regE),
        .mem_readE   (bus.mem_readE),
        .mem_writeE  (bus.mem_writeE),
        .alu_srcE    (bus.alu_srcE),
        .reg_dstE    (bus.reg_dstE),
        .alu_ctrlE   (bus.alu_ctrlE),
        .rd1E        (bus.rd1E),
        .rd2E        (bus.rd2E),
        .imm_extE    (bus.imm_extE),
        .pc_plus4E   (bus.pc_plus4E),
        .rs_addrE    (bus.rs_addrE),
        .rt_addrE    (bus.rt_addrE),
        .rd_addrE    (bus.rd_addrE),
        .validE      (bus.validE),
        .bubble_cnt  (bus.bubble_cnt)
    );

    // Control is packed {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_ctrl[3:0]}.
    typedef struct {
        logic        en, fl, cm;
        logic [9:0]  c;
        logic [31:0] r1, r2, im, pc;
        logic [4:0]  rs, rt, rd;
        logic [9:0]  ec;
        logic [31:0] er1, er2, eim, epc;
        logic [4:0]  ers, ert, erd;
        logic        ev;
        int          cinc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    function automatic logic [9:0] ctrl_out();
        return {bus.reg_writeE, bus.mem_to_regE, bus.mem_readE, bus.mem_writeE,
                bus.alu_srcE, bus.reg_dstE, bus.alu_ctrlE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic m, input logic [9:0] c,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        bus.en = e;
        bus.flushE = f;
        bus.control_mux = m;
        {bus.reg_writeD, bus.mem_to_regD, bus.mem_readD, bus.mem_writeD,
         bus.alu_srcD, bus.reg_dstD, bus.alu_ctrlD} = c;
        bus.rd1D = r1;
        bus.rd2D = r2;
        bus.imm_extD = im;
        bus.pc_plus4D = pc;
        bus.rs_addrD = rs;
        bus.rt_addrD = rt;
        bus.rd_addrD = rd;
    endtask

    task automatic check_all(input string tag, input logic [9:0] ec, input logic [31:0] er1,
                             input logic [31:0] er2, input logic [31:0] eim, input logic [31:0] epc,
                             input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                             input logic ev);
        chk({tag, ".ctrl"},  {22'd0, ctrl_out()}, {22'd0, ec});
        chk({tag, ".rd1"},   bus.rd1E, er1);
        chk({tag, ".rd2"},   bus.rd2E, er2);
        chk({tag, ".imm"},   bus.imm_extE, eim);
        chk({tag, ".pc4"},   bus.pc_plus4E, epc);
        chk({tag, ".rs"},    {27'd0, bus.rs_addrE}, {27'd0, ers});
        chk({tag, ".rt"},    {27'd0, bus.rt_addrE}, {27'd0, ert});
        chk({tag, ".rd"},    {27'd0, bus.rd_addrE}, {27'd0, erd});
        chk({tag, ".valid"}, {31'd0, bus.validE}, {31'd0, ev});
        chk({tag, ".bcnt"},  bus.bubble_cnt, exp_cnt);
    endtask

    initial begin
        vecs[0] = '{1, 0, 1, 10'h080, 32'h12345678, 32'hA5A5A5A5, 32'h00000010, 32'h00000404, 3, 9, 0,
                    10'h080, 32'h12345678, 32'hA5A5A5A5, 32'h00000010, 32'h00000404, 3, 9, 0, 1, 0};
        vecs[1] = '{1, 0, 0, 10'h2C5, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFC, 32'h00000408, 4, 7, 11,
                    10'h000, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFC, 32'h00000408, 4, 7, 11, 0, 1};
        vecs[2] = '{0, 0, 1, 10'h3FF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1, 2, 3,
                    10'h000, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFC, 32'h00000408, 4, 7, 11, 0, 0};
        vecs[3] = '{0, 0, 0, 10'h155, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 5, 6, 8,
                    10'h000, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFC, 32'h00000408, 4, 7, 11, 0, 0};
        vecs[4] = '{0, 0, 1, 10'h2AA, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 10, 12, 14,
                    10'h000, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFC, 32'h00000408, 4, 7, 11, 0, 0};
        vecs[5] = '{1, 0, 1, 10'h3FF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h00007FFF, 32'h00400000, 31, 30, 29,
                    10'h3FF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h00007FFF, 32'h00400000, 31, 30, 29, 1, 0};
        vecs[6] = '{0, 1, 1, 10'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 31, 31,
                    10'h000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1};
        vecs[7] = '{1, 0, 1, 10'h20F, 32'h00000ABC, 32'h00000DEF, 32'hFFFF8000, 32'h0000100C, 8, 16, 24,
                    10'h20F, 32'h00000ABC, 32'h00000DEF, 32'hFFFF8000, 32'h0000100C, 8, 16, 24, 1, 0};
        vecs[8] = '{1, 1, 0, 10'h3C0, 32'h13572468, 32'h24681357, 32'h00000001, 32'h00002000, 2, 3, 4,
                    10'h000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1};
        vecs[9] = '{1, 0, 1, 10'h001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFC, 0, 31, 1,
                    10'h001, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFC, 0, 31, 1, 1, 0};

        // Reset with every D input driven high.
        rst = 1'b1;
        drive(1, 0, 1, 10'h3FF, '1, '1, '1, '1, '1, '1, '1);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 10'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn reset: valid=%0d bcnt=%0d", bus.validE, bus.bubble_cnt);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].fl, vecs[i].cm, vecs[i].c, vecs[i].r1, vecs[i].r2,
                  vecs[i].im, vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            @(posedge clk);
            #1;
            if (CNT_EN) exp_cnt = exp_cnt + 32'(vecs[i].cinc);
            check_all($sformatf("vec%0d", i), vecs[i].ec, vecs[i].er1, vecs[i].er2, vecs[i].eim,
                      vecs[i].epc, vecs[i].ers, vecs[i].ert, vecs[i].erd, vecs[i].ev);
            $display("txn vec%0d: en=%0d fl=%0d cm=%0d -> ctrl=%h rd1=%h rt=%0d valid=%0d bcnt=%0d",
                     i, vecs[i].en, vecs[i].fl, vecs[i].cm, ctrl_out(), bus.rd1E,
                     bus.rt_addrE, bus.validE, bus.bubble_cnt);
        end

        // Reset mid-run while stalled: reset wins over hold.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 1, 10'h3FF, 32'h1, 32'h2, 32'h3, 32'h4, 5, 6, 7);
        @(posedge clk);
        #1;
        exp_cnt = 32'd0;
        check_all("rst_hold", 10'h000, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("txn rst_hold: valid=%0d bcnt=%0d", bus.validE, bus.bubble_cnt);
        @(negedge clk);
        rst = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
        // Preload the counter just below saturation, then issue three bubbles.
        force dut.cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_reg;
        drive(1, 0, 0, 10'h080, 32'h1, 32'h2, 32'h3, 32'h4, 5, 6, 7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d", k), bus.bubble_cnt, 32'hFFFF_FFFF);
            $display("txn sat%0d: bcnt=%h", k, bus.bubble_cnt);
            @(negedge clk);
        end
`else
        drive(1, 0, 0, 10'h080, 32'h1, 32'h2, 32'h3, 32'h4, 5, 6, 7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nocnt%0d", k), bus.bubble_cnt, 32'd0);
            chk($sformatf("nocnt_valid%0d", k), {31'd0, bus.validE}, 32'd0);
            $display("txn nocnt%0d: bcnt=%h valid=%0d", k, bus.bubble_cnt, bus.validE);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
